// File: rtl/bnn_layer_sequencer.sv
// Layer-level controller: steps one BNN inference through CONV1..FCL2, presenting
// per-layer config, clear/launch pulses, a per-layer watchdog and host status.
module bnn_layer_sequencer #(
  parameter int                TMO_WL  = 16,
  parameter logic [TMO_WL-1:0] TMO_MAX = 16'hFFFF
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSTART,
  input  logic       iABORT,
  input  logic       iLAYER_DONE,
  input  logic       iRESULT_VALID,
  input  logic [3:0] iRESULT,
  output logic       oLAYER_RST,
  output logic       oLAYER_START,
  output logic [2:0] oLAYER,
  output logic [8:0] oTH_OFFSET,
  output logic [3:0] oACC_MAX,
  output logic [8:0] oWR_COUNT,
  output logic [8:0] oWR_BASE,
  output logic [8:0] oRD_BASE,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oERR,
  output logic [3:0] oCLASS
);

  typedef enum logic [2:0] {IDLE, CLR, LAUNCH, RUN, FINISH, ERR} state_t;

  localparam logic [2:0] L_NONE  = 3'b000;
  localparam logic [2:0] L_CONV1 = 3'b010;
  localparam logic [2:0] L_CONV2 = 3'b011;
  localparam logic [2:0] L_CONV3 = 3'b100;
  localparam logic [2:0] L_FCL1  = 3'b101;
  localparam logic [2:0] L_FCL2  = 3'b110;

  localparam logic [TMO_WL-1:0] TMO_LAST = TMO_MAX - 1'b1;

  typedef struct packed {
    logic [8:0] th;
    logic [3:0] acc;
    logic [8:0] wrcnt;
    logic [8:0] wrbase;
    logic [8:0] rdbase;
  } cfg_t;

  function automatic cfg_t layer_cfg(input logic [2:0] code);
    cfg_t c;
    c = '0;
    case (code)
      L_CONV1: c = '{th: 9'd0,   acc: 4'd9, wrcnt: 9'd252, wrbase: 9'd0,   rdbase: 9'd0};
      L_CONV2: c = '{th: 9'd112, acc: 4'd9, wrcnt: 9'd48,  wrbase: 9'd252, rdbase: 9'd0};
      L_CONV3: c = '{th: 9'd224, acc: 4'd9, wrcnt: 9'd6,   wrbase: 9'd0,   rdbase: 9'd252};
      L_FCL1:  c = '{th: 9'd336, acc: 4'd6, wrcnt: 9'd1,   wrbase: 9'd252, rdbase: 9'd0};
      L_FCL2:  c = '{th: 9'd0,   acc: 4'd6, wrcnt: 9'd0,   wrbase: 9'd0,   rdbase: 9'd252};
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t            state;
  cfg_t              cfg;
  logic [TMO_WL-1:0] wdt;

  assign oTH_OFFSET = cfg.th;
  assign oACC_MAX   = cfg.acc;
  assign oWR_COUNT  = cfg.wrcnt;
  assign oWR_BASE   = cfg.wrbase;
  assign oRD_BASE   = cfg.rdbase;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= IDLE;
      cfg          <= '0;
      wdt          <= '0;
      oLAYER       <= L_NONE;
      oLAYER_RST   <= 1'b0;
      oLAYER_START <= 1'b0;
      oBUSY        <= 1'b0;
      oDONE        <= 1'b0;
      oERR         <= 1'b0;
      oCLASS       <= 4'd0;
    end else begin
      oLAYER_RST   <= 1'b0;
      oLAYER_START <= 1'b0;
      if (iABORT && state != IDLE && state != ERR) begin
        state      <= IDLE;
        cfg        <= '0;
        oLAYER     <= L_NONE;
        oLAYER_RST <= 1'b1;
        oBUSY      <= 1'b0;
        oDONE      <= 1'b0;
      end else begin
        case (state)
          IDLE, ERR: begin
            if (iSTART) begin
              state      <= CLR;
              oLAYER     <= L_CONV1;
              cfg        <= layer_cfg(L_CONV1);
              oLAYER_RST <= 1'b1;
              oBUSY      <= 1'b1;
              oERR       <= 1'b0;
            end
          end
          CLR: begin
            state        <= LAUNCH;
            oLAYER_START <= 1'b1;
          end
          LAUNCH: begin
            state <= RUN;
            wdt   <= '0;
          end
          RUN: begin
            // Completion beats watchdog expiry when both land on the same edge.
            if (oLAYER == L_FCL2 && iRESULT_VALID) begin
              oCLASS <= iRESULT;
              state  <= FINISH;
            end else if (oLAYER != L_FCL2 && iLAYER_DONE) begin
              oLAYER     <= oLAYER + 3'd1;
              cfg        <= layer_cfg(oLAYER + 3'd1);
              oLAYER_RST <= 1'b1;
              state      <= CLR;
            end else if (wdt == TMO_LAST) begin
              state  <= ERR;
              oERR   <= 1'b1;
              oBUSY  <= 1'b0;
              oLAYER <= L_NONE;
              cfg    <= '0;
            end else begin
              wdt <= wdt + 1'b1;
            end
          end
          FINISH: begin
            // Two cycles: the first raises oDONE while still busy, the second retires.
            if (!oDONE) begin
              oDONE <= 1'b1;
            end else begin
              oDONE  <= 1'b0;
              oBUSY  <= 1'b0;
              oLAYER <= L_NONE;
              cfg    <= '0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bnn_layer_sequencer.md
# bnn_layer_sequencer

Layer-level controller for the BNN inference datapath. It steps a single inference through CONV1 → CONV2 → CONV3 → FCL1 → FCL2. For each layer it presents a registered configuration set: threshold ROM offset, accumulate length, write count, and MEM1 read/write bases. It pulses a datapath clear, launches the layer and waits for its done. It also runs a per-layer watchdog, captures the final class index, and reports busy/done/error status to the host.

## Interface
- TMO_WL, 16, width of the per-layer watchdog counter.
- TMO_MAX, 16'hFFFF, RUN cycles allowed per layer before an error is declared.

- iCLK  in  1  clock.
- iRST  in  1  reset; synchronous, active-high.
- iSTART  in  1  start one inference; sampled only in IDLE or ERR.
- iABORT  in  1  abort the current inference.
- iLAYER_DONE  in  1  one-cycle pulse from the datapath: the current layer is complete.
- iRESULT_VALID  in  1  FCL2 class result valid.
- iRESULT  in  4  FCL2 class index.
- oLAYER_RST  out  1  one-cycle datapath clear pulse.
- oLAYER_START  out  1  one-cycle layer launch pulse.
- oLAYER  out  3  current layer code: CONV1=3'b010, CONV2=3'b011, CONV3=3'b100, FCL1=3'b101, FCL2=3'b110, none=3'b000.
- oTH_OFFSET  out  9  threshold ROM base for the layer.
- oACC_MAX  out  4  accumulate length for the layer.
- oWR_COUNT  out  9  MEM1 words the layer writes.
- oWR_BASE  out  9  MEM1 write base.
- oRD_BASE  out  9  MEM1 read base.
- oBUSY  out  1  high from the cycle after an accepted iSTART until return to IDLE/ERR.
- oDONE  out  1  one-cycle pulse on successful completion.
- oERR  out  1  sticky watchdog error; cleared by an accepted iSTART or by iRST.
- oCLASS  out  4  last captured class index; holds its value until the next capture.

## Operation
- FSM states: IDLE, CLR, LAUNCH, RUN, FINISH, ERR.
- IDLE/ERR + iSTART → CLR with layer = CONV1. Entering CLR clears oERR.
- CLR: oLAYER_RST=1. Config outputs load from the layer table. → LAUNCH.
- LAUNCH: oLAYER_START=1; watchdog counter cleared. → RUN.
- RUN, non-final layer: on iLAYER_DONE, advance to the next layer → CLR.
- RUN, FCL2: on iRESULT_VALID, oCLASS ← iRESULT → FINISH. iLAYER_DONE is ignored in FCL2.
- RUN watchdog: counter increments each RUN cycle. When the count equals TMO_MAX with no completion event, go to ERR with oERR=1 and oLAYER=3'b000.
- FINISH: oDONE=1 → IDLE.
- Layer table (TH, ACC, WRCNT, WRBASE, RDBASE):
  - CONV1 0, 9, 252, 0, 0
  - CONV2 112, 9, 48, 252, 0
  - CONV3 224, 9, 6, 0, 252
  - FCL1 336, 6, 1, 252, 0
  - FCL2 0, 6, 0, 0, 252
- IDLE/ERR: config outputs are 0.
- iABORT in CLR/LAUNCH/RUN/FINISH → IDLE next cycle, with oLAYER_RST=1 in that transition cycle, no oDONE, and oCLASS unchanged. iABORT in IDLE/ERR is ignored.
- Priority in the same cycle: iABORT > completion event > watchdog expiry.
- iSTART outside IDLE/ERR is ignored and has no queueing.

## Timing
- Reset (iRST=1 at an edge): state=IDLE; all outputs 0, including oCLASS and oERR.
- All outputs are registered.
- iSTART accepted at edge N: oLAYER_RST and oBUSY high after edge N, oLAYER_START high after edge N+1, RUN entered after edge N+2.
- iLAYER_DONE sampled at edge M → next layer's oLAYER_RST after M, oLAYER_START after M+1. Per-layer overhead is 2 cycles.
- Config outputs are stable from the CLR cycle through the end of RUN.
- iRESULT_VALID at edge K in FCL2: oCLASS updates after K, oDONE pulses after K+1, oBUSY drops after K+2.
- Watchdog expiry occurs at the TMO_MAX-th RUN cycle; oBUSY drops the same edge oERR rises.

## Test plan
- Nominal run: iSTART, then iLAYER_DONE 20 cycles after each launch, then iRESULT_VALID with iRESULT=4'd7 in FCL2 → five oLAYER_START pulses with oLAYER 010..110 and table config values, oCLASS=7, one oDONE, oBUSY low afterwards.
- Watchdog: TMO_MAX=16, no done in CONV2 → oERR=1 exactly at the 16th RUN cycle, oLAYER=0. A later iSTART clears oERR and restarts at CONV1.
- Abort mid-CONV3 → next cycle IDLE, oLAYER_RST pulse, no oDONE, oCLASS retains its prior value.
- Simultaneous events: iLAYER_DONE together with watchdog expiry → advances with no error. iABORT together with iLAYER_DONE → IDLE.
- iSTART while busy → ignored. iLAYER_DONE during FCL2 → ignored. iRST asserted in RUN → all outputs 0 the next cycle.
